updown_mod_counter: RTL

UPDOWN_MOD_COUNTER -- requirements
Module: updown_mod_counter

---
 rtl/updown_mod_counter.sv | 74 +++++++
 1 files changed

// File: rtl/updown_mod_counter.sv
// Up/down counter over the runtime range 0..max_val, with sync clear, parallel load,
// and either wrap-around (registered one-cycle wrap pulse) or saturation at the bounds.
module updown_mod_counter #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned INIT     = 0,
    parameter int unsigned SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] max_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] InitVal = WIDTH'(INIT);
    localparam logic [WIDTH-1:0] One     = WIDTH'(1);
    localparam logic [WIDTH-1:0] Zero    = '0;

    logic [WIDTH-1:0] count_d, count_q;
    logic             wrap_d, wrap_q;
    logic             at_top, at_bottom;

    // ">=" so a count left above a lowered max_val still wraps or clamps on the next up-count.
    assign at_top    = (count_q >= max_val);
    assign at_bottom = (count_q == Zero);

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (!rst) begin
            count_d = InitVal;
        end else if (clr) begin
            count_d = Zero;
        end else if (load) begin
            count_d = (load_val > max_val) ? max_val : load_val;
        end else if (en) begin
            if (up) begin
                if (!at_top) begin
                    count_d = count_q + One;
                end else if (SATURATE != 0) begin
                    count_d = max_val;
                end else begin
                    count_d = Zero;
                    wrap_d  = 1'b1;
                end
            end else begin
                if (!at_bottom) begin
                    count_d = count_q - One;
                end else if (SATURATE != 0) begin
                    count_d = Zero;
                end else begin
                    count_d = max_val;
                    wrap_d  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        count_q <= count_d;
        wrap_q  <= wrap_d;
    end

    assign count = count_q;
    assign wrap  = wrap_q;
    assign tc    = en & ((up & at_top) | (~up & at_bottom));

endmodule
